rom_loader_mc: RTL and testbench
================================

# rom_loader_mc

Multi-target ROM download sequencer in the `clk_ram` domain. It accepts 16-bit download words from the HPS download stream and fans each word out to up to `NUM_TGT` memory back-ends (SDRAM, DDR3, …) using toggle request/acknowledge handshakes. It holds the download stream stalled until every enabled target has acknowledged, then advances the write address. It replaces the fixed two-target write path and adds:
- a per-target enable mask;
- selectable byte/bit swap;
- ack-timeout error detection;
- end-of-download size and copier-header reporting.

## Interface
Parameters:
- `ADDR_W`, 24, width of the byte write address.
- `NUM_TGT`, 2, number of memory targets.
- `TIMEOUT`, 4096, cycles to wait for acks before flagging an error (≥2).

Ports:
- `clk_ram` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `dl_active` in 1: download in progress (level, already synchronised to `clk_ram`).
- `dl_wr` in 1: one-cycle strobe, a data word is valid.
- `dl_data` in 16: download word.
- `dl_wait` out 1: stall to the download source.
- `swap_mode` in 2: 0 none, 1 byte swap, 2 bit reverse within each byte, 3 bit reverse of the full 16 bits.
- `tgt_en` in NUM_TGT: target enable mask, sampled at download start.
- `tgt_req` out NUM_TGT: per-target request toggles.
- `tgt_ack` in NUM_TGT: per-target acknowledge toggles.
- `tgt_addr` out ADDR_W: byte address of the current word.
- `tgt_data` out 16: swapped current word.
- `done` out 1: pulse on download completion.
- `rom_size` out ADDR_W: bytes written in the last download.
- `hdr_512` out 1: `rom_size[9]`, i.e. a 512-byte copier header is present.
- `err_timeout` out 1: sticky, an ack wait expired.
- `err_overrun` out 1: sticky, `dl_wr` arrived while stalled.

## Operation
- States: `IDLE`, `READY`, `WAIT_ACK`, `FINISH`.
- **IDLE**
  - On a rising edge of `dl_active`: clear `tgt_addr`, `err_*`, `rom_size` and `hdr_512`; latch `tgt_en` into `en_q`; go to `READY`.
  - `tgt_en` is ignored at all other times.
- **READY**
  - On `dl_wr`: latch `dl_data` through the swap network into `tgt_data`; toggle `tgt_req[i]` for every `i` with `en_q[i]`; set `dl_wait`; clear the timeout counter; go to `WAIT_ACK`.
  - On `dl_active` falling: go to `FINISH`.
- **WAIT_ACK**
  - Ack match condition: `(tgt_req ^ tgt_ack) & en_q == 0`.
  - When matched: `tgt_addr += 2`, clear `dl_wait`, go to `READY`.
  - If the counter reaches `TIMEOUT-1` with no match: set `err_timeout`, force the address advance and the release of `dl_wait`, go to `READY`. Targets still owing an ack are marked out of `en_q` for the rest of the download.
  - `dl_wr` seen in this state: set `err_overrun`; the word is dropped.
  - `dl_active` falling in this state: finish the handshake first, then go to `FINISH`.
- **FINISH**: `rom_size <= tgt_addr`; `hdr_512 <= tgt_addr[9]`; pulse `done` for 1 cycle; go to `IDLE`.
- **Disabled targets**: their `tgt_req` bit never toggles. If `en_q == 0`, the match condition is true immediately (one-cycle `WAIT_ACK`).
- **Address wrap**: the address wraps modulo 2^ADDR_W silently; no error.
- **Swap**: purely combinational on the latched data path. Mode 3 matches the legacy "ROM data swap" bit ordering.

## Timing
- **Reset values**:
  - `dl_wait = 0`, `tgt_req = 0`, `tgt_addr = 0`, `tgt_data = 0`;
  - `done = 0`, `rom_size = 0`, `hdr_512 = 0`, `err_* = 0`;
  - state `IDLE`.
- **Reset mid-download**:
  - Returns everything to the reset values, and `tgt_req` returns to 0.
  - Targets must also be reset, or their ack toggles will mismatch.
  - `dl_wait` drops in the reset cycle.
- **Request latency**: `dl_wr` at cycle N gives `tgt_req`, `tgt_data` and `dl_wait` updated at N+1. `tgt_addr` is stable from N+1 until the ack match.
- **Ack latency**: an ack match sampled at cycle M gives the address increment and `dl_wait` low at M+1. Minimum turnaround is 2 cycles per word.
- **Simultaneous events**:
  - `dl_wr` together with `dl_active` falling in `READY`: the word is accepted, then the block finishes.
  - Ack match in the same cycle the timeout expires: treated as a match, no error.
- **Done timing**: `done` asserts exactly 1 cycle, 1 cycle after entering `FINISH`.

## Structure
- Package `rom_loader_pkg`:
  - state enum `ldr_state_t`;
  - swap mode constants `SWAP_NONE`, `SWAP_BYTE`, `SWAP_BITB`, `SWAP_BIT16`;
  - function `swap16(data, mode)`.
- Sub-module `toggle_hs_tracker` (one per target, via generate): holds the request toggle and the `pending` flag, and exposes `pending`.

## Test plan
- **Basic write**: 2 targets enabled, 4 words `0x1234, 0x5678, 0x9ABC, 0xDEF0`, acks at +3 and +7 cycles. Expect addresses `0, 2, 4, 6`; `dl_wait` held until the later ack; `done`; `rom_size = 8`; `hdr_512 = 0`.
- **Header detect and swap**: 256+1024 words (2560 bytes), `swap_mode = 1`, data `0x1234`. Expect `tgt_data = 0x3412`; `rom_size = 0xA00`; `hdr_512 = 1`.
- **Mask**: `tgt_en = 2'b10`, target 0 never acks. Expect `tgt_req[0]` constant at 0; no stall beyond target 1's ack; no error.
- **Timeout**: `TIMEOUT = 16`, target 1 silent. Expect `err_timeout` set 16 cycles after the request, address advanced, later words gated only by target 0.
- **Overrun**: `dl_wr` pulsed during `WAIT_ACK`. Expect `err_overrun = 1`; the word is not forwarded; address count unchanged by it.
- **Reset mid-download**: `reset` after 3 words with an ack outstanding. Expect all outputs at reset values the next cycle; a new download starts at address 0.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types, swap-mode encodings and the download-word swap network for rom_loader_mc.
package rom_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    WAIT_ACK = 2'd2,
    FINISH   = 2'd3
  } ldr_state_t;

  localparam logic [1:0] SWAP_NONE  = 2'd0;
  localparam logic [1:0] SWAP_BYTE  = 2'd1;
  localparam logic [1:0] SWAP_BITB  = 2'd2;
  localparam logic [1:0] SWAP_BIT16 = 2'd3;

  // SWAP_BIT16 is the legacy "ROM data swap" ordering: bit i <- bit 15-i.
  function automatic logic [15:0] swap16(input logic [15:0] data, input logic [1:0] mode);
    logic [15:0] r;
    r = data;
    case (mode)
      SWAP_BYTE: r = {data[7:0], data[15:8]};
      SWAP_BITB: begin
        for (int i = 0; i < 8; i++) begin
          r[i]     = data[7 - i];
          r[8 + i] = data[15 - i];
        end
      end
      SWAP_BIT16: begin
        for (int i = 0; i < 16; i++) r[i] = data[15 - i];
      end
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rom_loader_mc_tracker.sv
// Per-target toggle request generator; pending is high while the target owes an ack.
module toggle_hs_tracker (
  input  logic clk_ram,
  input  logic reset,
  input  logic fire,
  input  logic ack,
  output logic req,
  output logic pending
);

  always_ff @(posedge clk_ram) begin
    if (reset)     req <= 1'b0;
    else if (fire) req <= ~req;
  end

  assign pending = req ^ ack;

endmodule

// File: rtl/rom_loader_mc.sv
// Multi-target ROM download sequencer: fans each download word out to the enabled
// memory targets and stalls the download stream until all of them have acknowledged.
module rom_loader_mc
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int NUM_TGT = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk_ram,
  input  logic               reset,
  input  logic               dl_active,
  input  logic               dl_wr,
  input  logic [15:0]        dl_data,
  output logic               dl_wait,
  input  logic [1:0]         swap_mode,
  input  logic [NUM_TGT-1:0] tgt_en,
  output logic [NUM_TGT-1:0] tgt_req,
  input  logic [NUM_TGT-1:0] tgt_ack,
  output logic [ADDR_W-1:0]  tgt_addr,
  output logic [15:0]        tgt_data,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_size,
  output logic               hdr_512,
  output logic               err_timeout,
  output logic               err_overrun
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ldr_state_t         state;
  logic               active_q;
  logic [NUM_TGT-1:0] en_q;
  logic [NUM_TGT-1:0] pending;
  logic [NUM_TGT-1:0] fire;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               ack_match;

  assign accept    = (state == READY) && dl_wr;
  assign fire      = accept ? en_q : '0;
  assign ack_match = ((pending & en_q) == '0);

  for (genvar i = 0; i < NUM_TGT; i++) begin : g_tgt
    toggle_hs_tracker u_trk (
      .clk_ram (clk_ram),
      .reset   (reset),
      .fire    (fire[i]),
      .ack     (tgt_ack[i]),
      .req     (tgt_req[i]),
      .pending (pending[i])
    );
  end

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state       <= IDLE;
      active_q    <= 1'b0;
      en_q        <= '0;
      tgt_addr    <= '0;
      tgt_data    <= '0;
      dl_wait     <= 1'b0;
      done        <= 1'b0;
      rom_size    <= '0;
      hdr_512     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      cnt         <= '0;
    end else begin
      active_q <= dl_active;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (dl_active && !active_q) begin
            tgt_addr    <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            rom_size    <= '0;
            hdr_512     <= 1'b0;
            en_q        <= tgt_en;
            state       <= READY;
          end
        end
        READY: begin
          // A word arriving with the falling edge is still taken; FINISH follows the handshake.
          if (dl_wr) begin
            tgt_data <= swap16(dl_data, swap_mode);
            dl_wait  <= 1'b1;
            cnt      <= '0;
            state    <= WAIT_ACK;
          end else if (!dl_active) begin
            state <= FINISH;
          end
        end
        WAIT_ACK: begin
          if (dl_wr) err_overrun <= 1'b1;
          if (ack_match) begin
            tgt_addr <= tgt_addr + ADDR_W'(2);
            dl_wait  <= 1'b0;
            state    <= READY;
          end else if (cnt == CNT_LAST) begin
            // Silent targets are dropped so the rest of the download is not throttled by them.
            err_timeout <= 1'b1;
            en_q        <= en_q & ~pending;
            tgt_addr    <= tgt_addr + ADDR_W'(2);
            dl_wait     <= 1'b0;
            state       <= READY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          rom_size <= tgt_addr;
          hdr_512  <= tgt_addr[9];
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader_mc.sv
// Directed self-checking bench for rom_loader_mc with a delay-programmable toggle-ack responder.
module tb_rom_loader_mc;

  logic        clk_ram = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [15:0] dl_data = '0;
  logic        dl_wait;
  logic [1:0]  swap_mode = '0;
  logic [1:0]  tgt_en = '0;
  logic [1:0]  tgt_req;
  logic [1:0]  tgt_ack = '0;
  logic [23:0] tgt_addr;
  logic [15:0] tgt_data;
  logic        done;
  logic [23:0] rom_size;
  logic        hdr_512;
  logic        err_timeout;
  logic        err_overrun;

  int total = 0;
  int bad = 0;
  int exp_addr = 0;
  int dly[2];
  int acnt[2];
  logic [1:0] silent = '0;

  rom_loader_mc #(.ADDR_W(24), .NUM_TGT(2), .TIMEOUT(16)) dut (
    .clk_ram     (clk_ram),
    .reset       (reset),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait),
    .swap_mode   (swap_mode),
    .tgt_en      (tgt_en),
    .tgt_req     (tgt_req),
    .tgt_ack     (tgt_ack),
    .tgt_addr    (tgt_addr),
    .tgt_data    (tgt_data),
    .done        (done),
    .rom_size    (rom_size),
    .hdr_512     (hdr_512),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk_ram = ~clk_ram;

  // Target model: each owed ack is returned dly[i] negedges after it becomes owed.
  always @(negedge clk_ram) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        tgt_ack[i] = 1'b0;
        acnt[i] = 0;
      end else if (!silent[i] && (tgt_req[i] != tgt_ack[i])) begin
        acnt[i]++;
        if (acnt[i] >= dly[i]) begin
          tgt_ack[i] = tgt_req[i];
          acnt[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_wait", 32'(dl_wait), 0);
    chk("rst_req", 32'(tgt_req), 0);
    chk("rst_addr", 32'(tgt_addr), 0);
    chk("rst_data", 32'(tgt_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_size", 32'(rom_size), 0);
    chk("rst_hdr", 32'(hdr_512), 0);
    chk("rst_errt", 32'(err_timeout), 0);
    chk("rst_erro", 32'(err_overrun), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dl_active = 1'b0;
    dl_wr = 1'b0;
    tick();
    tick();
    check_reset_vals();
    reset = 1'b0;
    tick();
  endtask

  task automatic start_dl(input logic [1:0] en);
    tgt_en = en;
    dl_active = 1'b1;
    exp_addr = 0;
    tick();
    tgt_en = 2'b00;
    chk("start_wait", 32'(dl_wait), 0);
    chk("start_addr", 32'(tgt_addr), 0);
  endtask

  task automatic accept_word(input logic [15:0] d, input logic [1:0] m, input logic [15:0] expd);
    dl_data = d;
    swap_mode = m;
    dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    chk("acc_wait", 32'(dl_wait), 1);
    chk("acc_addr", 32'(tgt_addr), 32'(exp_addr));
    chk("acc_data", 32'(tgt_data), 32'(expd));
  endtask

  task automatic wait_release(output int cyc);
    cyc = 0;
    while (dl_wait && cyc < 100) begin
      tick();
      cyc++;
    end
    exp_addr += 2;
    chk("rel_addr", 32'(tgt_addr), 32'(exp_addr));
  endtask

  task automatic send_word(input logic [15:0] d, input logic [1:0] m, input logic [15:0] expd,
                           output int cyc);
    accept_word(d, m, expd);
    wait_release(cyc);
  endtask

  task automatic end_dl(input int exp_size, input logic exp_hdr);
    int cyc;
    dl_active = 1'b0;
    cyc = 0;
    while (!done && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("done_lat", 32'(cyc), 2);
    chk("rom_size", 32'(rom_size), 32'(exp_size));
    chk("hdr_512", 32'(hdr_512), 32'(exp_hdr));
    tick();
    chk("done_pulse", 32'(done), 0);
  endtask

  initial begin
    int cyc;
    logic [1:0] req_snap;
    dly[0] = 3;
    dly[1] = 7;
    acnt[0] = 0;
    acnt[1] = 0;

    do_reset();

    // Basic: both targets, dl_wait held until the slower (7-cycle) ack.
    start_dl(2'b11);
    send_word(16'h1234, 2'd0, 16'h1234, cyc);
    chk("basic_wait0", 32'(cyc), 7);
    chk("basic_req0", 32'(tgt_req), 32'(2'b11));
    send_word(16'h5678, 2'd0, 16'h5678, cyc);
    chk("basic_wait1", 32'(cyc), 7);
    chk("basic_req1", 32'(tgt_req), 0);
    send_word(16'h9ABC, 2'd0, 16'h9ABC, cyc);
    send_word(16'hDEF0, 2'd0, 16'hDEF0, cyc);
    chk("basic_noerr", 32'({err_timeout, err_overrun}), 0);
    end_dl(8, 1'b0);

    // Overrun: a strobe during WAIT_ACK is flagged and dropped.
    dly[0] = 1;
    dly[1] = 6;
    start_dl(2'b11);
    accept_word(16'h1111, 2'd0, 16'h1111);
    req_snap = tgt_req;
    tick();
    dl_data = 16'hFFFF;
    dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    chk("ovr_flag", 32'(err_overrun), 1);
    chk("ovr_data", 32'(tgt_data), 32'h1111);
    chk("ovr_req", 32'(tgt_req), 32'(req_snap));
    chk("ovr_addr", 32'(tgt_addr), 0);
    wait_release(cyc);
    send_word(16'h2222, 2'd0, 16'h2222, cyc);
    chk("ovr_sticky", 32'(err_overrun), 1);
    end_dl(4, 1'b0);

    // Header detect and swap modes: 1280 words = 0xA00 bytes.
    dly[0] = 1;
    dly[1] = 2;
    start_dl(2'b11);
    chk("new_dl_clr_ovr", 32'(err_overrun), 0);
    send_word(16'h1234, 2'd2, 16'h482C, cyc);
    send_word(16'h1234, 2'd3, 16'h2C48, cyc);
    for (int w = 2; w < 1280; w++) send_word(16'h1234, 2'd1, 16'h3412, cyc);
    end_dl(32'hA00, 1'b1);

    // Mask: only target 1 enabled, target 0 silent and never requested.
    do_reset();
    silent = 2'b01;
    dly[1] = 2;
    start_dl(2'b10);
    for (int w = 0; w < 3; w++) begin
      send_word(16'hA5A5, 2'd0, 16'hA5A5, cyc);
      chk("mask_wait", 32'(cyc), 2);
      chk("mask_req0", 32'(tgt_req[0]), 0);
    end
    chk("mask_noerr", 32'(err_timeout), 0);
    end_dl(6, 1'b0);

    // Timeout: target 1 silent; first word released after 16 cycles, then gated by target 0 only.
    do_reset();
    silent = 2'b10;
    dly[0] = 1;
    start_dl(2'b11);
    send_word(16'h0F0F, 2'd0, 16'h0F0F, cyc);
    chk("to_cycles", 32'(cyc), 16);
    chk("to_flag", 32'(err_timeout), 1);
    req_snap = tgt_req;
    send_word(16'h0101, 2'd0, 16'h0101, cyc);
    chk("to_fast", 32'(cyc), 1);
    chk("to_req1_frozen", 32'(tgt_req[1]), 32'(req_snap[1]));
    chk("to_sticky", 32'(err_timeout), 1);
    end_dl(4, 1'b0);

    // Reset mid-download with target 1's ack outstanding.
    silent = 2'b00;
    dly[0] = 1;
    dly[1] = 1;
    do_reset();
    start_dl(2'b11);
    send_word(16'h1357, 2'd0, 16'h1357, cyc);
    send_word(16'h2468, 2'd0, 16'h2468, cyc);
    silent = 2'b10;
    accept_word(16'h9999, 2'd0, 16'h9999);
    tick();
    reset = 1'b1;
    dl_active = 1'b0;
    tick();
    check_reset_vals();
    reset = 1'b0;
    silent = 2'b00;
    tick();
    start_dl(2'b11);
    send_word(16'h4242, 2'd0, 16'h4242, cyc);
    chk("post_rst_wait", 32'(cyc), 1);
    end_dl(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
